// File: rtl/tour_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// tour_cmd_sequencer_if
//   Command/response link between the script sequencer and RemoteComm.
//   cmd       16  command word presented to RemoteComm
//   send_cmd   1  one-cycle request to transmit cmd
//   cmd_sent   1  RemoteComm has finished transmitting the command
//   resp_rdy   1  response byte valid (pulse)
//   resp       8  response byte
//   master: the sequencer (drives cmd/send_cmd)
//   slave : RemoteComm (drives cmd_sent/resp_rdy/resp)
// ---------------------------------------------------------------------------
interface tour_cmd_sequencer_if;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output send_cmd,
    input  cmd_sent,
    input  resp_rdy,
    input  resp
  );

  modport slave (
    input  cmd,
    input  send_cmd,
    output cmd_sent,
    output resp_rdy,
    output resp
  );
endinterface

// File: rtl/tour_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tour_cmd_sequencer
//   Command-script player for the Knight's Tour system. A loadable table of
//   DEPTH entries {cmd, expected response, check flag} is played in order to
//   RemoteComm: each entry is issued with a one-cycle send_cmd, then the
//   sequencer waits (with programmable timeouts) for cmd_sent and resp_rdy
//   and optionally compares the response byte against the expected value.
//
// Parameters
//   DEPTH        script entries (power of 2, >= 2)
//   TMO_W        width of the timeout counter and timeout inputs
//   STOP_ON_ERR  1: stop at first error; 0: record first error, keep going
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/
//   wr_cmd/wr_exp/wr_chk script table write port (accepted only when idle)
//   num_cmds            entries to play (0..DEPTH), sampled at start
//   sent_tmo, resp_tmo  max wait cycles for cmd_sent / resp_rdy
//   start, abort        begin playback / cancel playback
//   rc                  RemoteComm link (master side)
//   busy, done          playback in progress / playback finished (level)
//   err, err_code,
//   err_idx             sticky error, first error code (01 sent timeout,
//                       10 mismatch, 11 resp timeout) and its entry index
//   pass_cnt            entries completed without error this run
// ---------------------------------------------------------------------------
module tour_cmd_sequencer #(
  parameter  int DEPTH       = 16,
  parameter  int TMO_W       = 24,
  parameter  bit STOP_ON_ERR = 1'b1,
  localparam int IW          = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_addr,
  input  logic [15:0]          wr_cmd,
  input  logic [7:0]           wr_exp,
  input  logic                 wr_chk,
  input  logic [IW:0]          num_cmds,
  input  logic [TMO_W-1:0]     sent_tmo,
  input  logic [TMO_W-1:0]     resp_tmo,
  input  logic                 start,
  input  logic                 abort,
  tour_cmd_sequencer_if.master rc,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [IW-1:0]        err_idx,
  output logic [IW:0]          pass_cnt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_SENT = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;
  localparam logic [2:0] S_FIN       = 3'd5;

  localparam logic [1:0] E_SENT_TMO = 2'b01;
  localparam logic [1:0] E_MISMATCH = 2'b10;
  localparam logic [1:0] E_RESP_TMO = 2'b11;

  localparam logic [IW:0]      ONE_N   = (IW+1)'(1);
  localparam logic [IW-1:0]    ONE_I   = IW'(1);
  localparam logic [TMO_W-1:0] ONE_T   = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMR_MAX = '1;

  // Script table (not reset: contents are only meaningful once loaded)
  logic [15:0] mem_cmd [DEPTH];
  logic [7:0]  mem_exp [DEPTH];
  logic        mem_chk [DEPTH];

  logic [2:0]       state;
  logic [IW-1:0]    idx;
  logic [IW:0]      num_lat;
  logic [TMO_W-1:0] timer;
  logic [7:0]       resp_q;
  logic [15:0]      cmd_q;
  logic             send_q;

  logic             raise;
  logic [1:0]       raise_code;
  logic             last_entry;
  logic [2:0]       adv_state;
  logic [2:0]       err_state;
  logic [TMO_W-1:0] timer_inc;

  assign rc.cmd      = cmd_q;
  assign rc.send_cmd = send_q;

  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE)) begin
      mem_cmd[wr_addr] <= wr_cmd;
      mem_exp[wr_addr] <= wr_exp;
      mem_chk[wr_addr] <= wr_chk;
    end
  end

  // The "last entry" test uses idx before it is advanced.
  assign last_entry = ({1'b0, idx} == (num_lat - ONE_N));
  assign adv_state  = last_entry ? S_FIN : S_ISSUE;
  assign err_state  = STOP_ON_ERR ? S_FIN : adv_state;
  assign timer_inc  = (timer == TMR_MAX) ? timer : (timer + ONE_T);

  // Error detection for the current state. A handshake arriving on the
  // same cycle the timer reaches its limit wins over the timeout.
  always_comb begin
    raise      = 1'b0;
    raise_code = 2'b00;
    case (state)
      S_WAIT_SENT: begin
        if (!rc.cmd_sent && (timer == sent_tmo)) begin
          raise      = 1'b1;
          raise_code = E_SENT_TMO;
        end
      end
      S_WAIT_RESP: begin
        if (!rc.resp_rdy && (timer == resp_tmo)) begin
          raise      = 1'b1;
          raise_code = E_RESP_TMO;
        end
      end
      S_CHECK: begin
        if (mem_chk[idx] && (resp_q != mem_exp[idx])) begin
          raise      = 1'b1;
          raise_code = E_MISMATCH;
        end
      end
      default: begin
        raise      = 1'b0;
        raise_code = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      num_lat  <= '0;
      timer    <= '0;
      resp_q   <= '0;
      cmd_q    <= '0;
      send_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      err_idx  <= '0;
      pass_cnt <= '0;
    end else begin
      send_q <= 1'b0;
      if ((state != S_IDLE) && abort) begin
        // Abort leaves status fields holding their partial values.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        if (raise) begin
          err <= 1'b1;
          if (!err) begin
            err_code <= raise_code;
            err_idx  <= idx;
          end
        end

        case (state)
          S_IDLE: begin
            if (start) begin
              done     <= 1'b0;
              err      <= 1'b0;
              err_code <= 2'b00;
              err_idx  <= '0;
              pass_cnt <= '0;
              num_lat  <= num_cmds;
              idx      <= '0;
              busy     <= 1'b1;
              state    <= (num_cmds == '0) ? S_FIN : S_ISSUE;
            end
          end

          S_ISSUE: begin
            cmd_q  <= mem_cmd[idx];
            send_q <= 1'b1;
            timer  <= '0;
            state  <= S_WAIT_SENT;
          end

          S_WAIT_SENT: begin
            if (rc.cmd_sent) begin
              timer <= '0;
              if (rc.resp_rdy) begin
                resp_q <= rc.resp;
                state  <= S_CHECK;
              end else begin
                state  <= S_WAIT_RESP;
              end
            end else if (raise) begin
              if (!STOP_ON_ERR) idx <= idx + ONE_I;
              state <= err_state;
            end else begin
              timer <= timer_inc;
            end
          end

          S_WAIT_RESP: begin
            if (rc.resp_rdy) begin
              resp_q <= rc.resp;
              state  <= S_CHECK;
            end else if (raise) begin
              if (!STOP_ON_ERR) idx <= idx + ONE_I;
              state <= err_state;
            end else begin
              timer <= timer_inc;
            end
          end

          S_CHECK: begin
            if (raise) begin
              if (!STOP_ON_ERR) idx <= idx + ONE_I;
              state <= err_state;
            end else begin
              pass_cnt <= pass_cnt + ONE_N;
              idx      <= idx + ONE_I;
              state    <= adv_state;
            end
          end

          S_FIN: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tour_cmd_sequencer
//   Directed bench for tour_cmd_sequencer. Two instances share the script
//   write port and the RemoteComm response inputs: dut0 stops on the first
//   error, dut1 continues. A RemoteComm model answers each send_cmd of the
//   selected instance according to a per-entry table (delays, dropped
//   handshakes, same-cycle cmd_sent/resp_rdy, response byte).
// ---------------------------------------------------------------------------
module tb_tour_cmd_sequencer;
  localparam int DEPTH = 16;
  localparam int TMO_W = 24;
  localparam int IW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic wr_en;
  logic [IW-1:0] wr_addr;
  logic [15:0] wr_cmd;
  logic [7:0] wr_exp;
  logic wr_chk;
  logic [IW:0] num_cmds;
  logic [TMO_W-1:0] sent_tmo, resp_tmo;
  logic start0, start1, abort;
  logic busy0, done0, err0, busy1, done1, err1;
  logic [1:0] err_code0, err_code1;
  logic [IW-1:0] err_idx0, err_idx1;
  logic [IW:0] pass_cnt0, pass_cnt1;

  logic cmd_sent_d, resp_rdy_d;
  logic [7:0] resp_d;

  logic use1;
  logic s_busy, s_done, s_err, s_send;
  logic [1:0] s_code;
  logic [IW-1:0] s_idx;
  logic [IW:0] s_pass;
  logic [15:0] s_cmd;

  int sent_dly, resp_dly;
  logic drop_sent [8];
  logic drop_resp [8];
  logic same_cyc [8];
  logic [7:0] resp_val [8];
  logic [15:0] log_cmd [8];
  int npulse;
  int run_id;

  int tests, failures;

  always #5 clk = ~clk;

  tour_cmd_sequencer_if bus0 ();
  tour_cmd_sequencer_if bus1 ();

  assign bus0.cmd_sent = cmd_sent_d;
  assign bus0.resp_rdy = resp_rdy_d;
  assign bus0.resp     = resp_d;
  assign bus1.cmd_sent = cmd_sent_d;
  assign bus1.resp_rdy = resp_rdy_d;
  assign bus1.resp     = resp_d;

  tour_cmd_sequencer #(.DEPTH(DEPTH), .TMO_W(TMO_W), .STOP_ON_ERR(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_cmd(wr_cmd),
    .wr_exp(wr_exp), .wr_chk(wr_chk), .num_cmds(num_cmds), .sent_tmo(sent_tmo),
    .resp_tmo(resp_tmo), .start(start0), .abort(abort), .rc(bus0.master),
    .busy(busy0), .done(done0), .err(err0), .err_code(err_code0),
    .err_idx(err_idx0), .pass_cnt(pass_cnt0)
  );

  tour_cmd_sequencer #(.DEPTH(DEPTH), .TMO_W(TMO_W), .STOP_ON_ERR(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_cmd(wr_cmd),
    .wr_exp(wr_exp), .wr_chk(wr_chk), .num_cmds(num_cmds), .sent_tmo(sent_tmo),
    .resp_tmo(resp_tmo), .start(start1), .abort(abort), .rc(bus1.master),
    .busy(busy1), .done(done1), .err(err1), .err_code(err_code1),
    .err_idx(err_idx1), .pass_cnt(pass_cnt1)
  );

  assign s_busy = use1 ? busy1 : busy0;
  assign s_done = use1 ? done1 : done0;
  assign s_err  = use1 ? err1 : err0;
  assign s_code = use1 ? err_code1 : err_code0;
  assign s_idx  = use1 ? err_idx1 : err_idx0;
  assign s_pass = use1 ? pass_cnt1 : pass_cnt0;
  assign s_send = use1 ? bus1.send_cmd : bus0.send_cmd;
  assign s_cmd  = use1 ? bus1.cmd : bus0.cmd;

  // RemoteComm model: answers each send_cmd of the selected instance
  initial begin : responder
    int cnt, k, seen;
    cmd_sent_d = 1'b0; resp_rdy_d = 1'b0; resp_d = 8'h00;
    cnt = 0; seen = 0; npulse = 0;
    forever begin
      @(negedge clk);
      if (run_id != seen) begin seen = run_id; cnt = 0; npulse = 0; end
      if (s_send === 1'b1) begin
        k = (cnt > 7) ? 7 : cnt;
        log_cmd[k] = s_cmd;
        cnt++;
        npulse = cnt;
        if (!drop_sent[k]) begin
          repeat (sent_dly) @(negedge clk);
          cmd_sent_d = 1'b1;
          if (same_cyc[k]) begin resp_rdy_d = 1'b1; resp_d = resp_val[k]; end
          @(negedge clk);
          cmd_sent_d = 1'b0; resp_rdy_d = 1'b0;
          if (!same_cyc[k] && !drop_resp[k]) begin
            repeat (resp_dly - 1) @(negedge clk);
            resp_rdy_d = 1'b1; resp_d = resp_val[k];
            @(negedge clk);
            resp_rdy_d = 1'b0;
          end
        end
      end
    end
  end

  task automatic cfg_default();
    for (int i = 0; i < 8; i++) begin
      drop_sent[i] = 1'b0; drop_resp[i] = 1'b0; same_cyc[i] = 1'b0; resp_val[i] = 8'hA5;
    end
    sent_dly = 3; resp_dly = 4;
    sent_tmo = 24'd1000; resp_tmo = 24'd1000;
  endtask

  task automatic load(input logic [IW-1:0] a, input logic [15:0] c, input logic [7:0] e, input logic k);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_cmd = c; wr_exp = e; wr_chk = k;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [IW:0] n);
    @(negedge clk);
    run_id++;
    num_cmds = n;
    if (use1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int c;
    c = 0;
    while (!(s_done === 1'b1 && s_busy === 1'b0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (c >= budget) begin
      failures++;
      $display("FAIL %s_done_wait: done=%b busy=%b after %0d cycles, required done=1 busy=0", nm, s_done, s_busy, c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (s_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", s_busy); end
    tests++; if (s_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", s_done); end
    tests++; if (s_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", s_err); end
    tests++; if (s_code !== 2'b00) begin failures++; $display("FAIL reset_err_code: got %b required 00", s_code); end
    tests++; if (s_idx !== 4'd0) begin failures++; $display("FAIL reset_err_idx: got %0d required 0", s_idx); end
    tests++; if (s_pass !== 5'd0) begin failures++; $display("FAIL reset_pass_cnt: got %0d required 0", s_pass); end
    tests++; if (s_send !== 1'b0) begin failures++; $display("FAIL reset_send_cmd: got %b required 0", s_send); end
    tests++; if (s_cmd !== 16'h0000) begin failures++; $display("FAIL reset_cmd: got %h required 0000", s_cmd); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    cfg_default();
    sent_dly = 10; resp_dly = 50;
    load(4'd0, 16'h2000, 8'hA5, 1'b1);
    start_run(5'd1);
    tests++; if (s_send !== 1'b0) begin failures++; $display("FAIL single_latency_early: send_cmd=%b one cycle after start, required 0", s_send); end
    @(negedge clk);
    tests++; if (s_send !== 1'b1) begin failures++; $display("FAIL single_latency: send_cmd=%b two cycles after start, required 1", s_send); end
    tests++; if (s_cmd !== 16'h2000) begin failures++; $display("FAIL single_cmd_issue: got %h required 2000", s_cmd); end
    wait_done(300, "single");
    tests++; if (npulse !== 1) begin failures++; $display("FAIL single_pulses: got %0d required 1", npulse); end
    tests++; if (s_err !== 1'b0) begin failures++; $display("FAIL single_err: got %b required 0", s_err); end
    tests++; if (s_pass !== 5'd1) begin failures++; $display("FAIL single_pass_cnt: got %0d required 1", s_pass); end
    tests++; if (s_cmd !== 16'h2000) begin failures++; $display("FAIL single_cmd_hold: got %h required 2000", s_cmd); end
    repeat (5) @(negedge clk);
    tests++; if (s_done !== 1'b1) begin failures++; $display("FAIL single_done_level: got %b required 1", s_done); end
  endtask

  task automatic test_four_moves();
    logic [15:0] exp_cmd [4];
    exp_cmd[0] = 16'h4001; exp_cmd[1] = 16'h4E02; exp_cmd[2] = 16'h5801; exp_cmd[3] = 16'h5302;
    cfg_default();
    for (int i = 0; i < 4; i++) load(IW'(i), exp_cmd[i], 8'hA5, 1'b1);
    start_run(5'd4);
    // write attempted while busy must not reach the table
    load(4'd3, 16'hFFFF, 8'h00, 1'b1);
    wait_done(300, "four");
    tests++; if (npulse !== 4) begin failures++; $display("FAIL four_pulses: got %0d required 4", npulse); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (log_cmd[i] !== exp_cmd[i]) begin failures++; $display("FAIL four_cmd_%0d: got %h required %h", i, log_cmd[i], exp_cmd[i]); end
    end
    tests++; if (s_pass !== 5'd4) begin failures++; $display("FAIL four_pass_cnt: got %0d required 4", s_pass); end
    tests++; if (s_err !== 1'b0) begin failures++; $display("FAIL four_err: got %b required 0", s_err); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_stop_on_err();
    cfg_default();
    resp_val[2] = 8'h5A;
    start_run(5'd4);
    wait_done(300, "stop");
    tests++; if (s_err !== 1'b1) begin failures++; $display("FAIL stop_err: got %b required 1", s_err); end
    tests++; if (s_code !== 2'b10) begin failures++; $display("FAIL stop_err_code: got %b required 10", s_code); end
    tests++; if (s_idx !== 4'd2) begin failures++; $display("FAIL stop_err_idx: got %0d required 2", s_idx); end
    tests++; if (s_pass !== 5'd2) begin failures++; $display("FAIL stop_pass_cnt: got %0d required 2", s_pass); end
    repeat (20) @(negedge clk);
    tests++; if (npulse !== 3) begin failures++; $display("FAIL stop_pulses: got %0d required 3", npulse); end
  endtask

  task automatic test_continue_on_err();
    cfg_default();
    use1 = 1'b1;
    // dut1 accepted the write made while dut0 was busy; restore entry 3
    load(4'd3, 16'h5302, 8'hA5, 1'b1);
    resp_tmo = 24'd100;
    drop_resp[1] = 1'b1;
    start_run(5'd4);
    wait_done(600, "cont");
    tests++; if (npulse !== 4) begin failures++; $display("FAIL cont_pulses: got %0d required 4", npulse); end
    tests++; if (log_cmd[2] !== 16'h5801) begin failures++; $display("FAIL cont_cmd_2: got %h required 5801", log_cmd[2]); end
    tests++; if (log_cmd[3] !== 16'h5302) begin failures++; $display("FAIL cont_cmd_3: got %h required 5302", log_cmd[3]); end
    tests++; if (s_err !== 1'b1) begin failures++; $display("FAIL cont_err: got %b required 1", s_err); end
    tests++; if (s_code !== 2'b11) begin failures++; $display("FAIL cont_err_code: got %b required 11", s_code); end
    tests++; if (s_idx !== 4'd1) begin failures++; $display("FAIL cont_err_idx: got %0d required 1", s_idx); end
    tests++; if (s_pass !== 5'd3) begin failures++; $display("FAIL cont_pass_cnt: got %0d required 3", s_pass); end
    repeat (10) @(negedge clk);
    use1 = 1'b0;
  endtask

  task automatic test_sent_timeout();
    int c;
    cfg_default();
    sent_tmo = 24'd20;
    drop_sent[0] = 1'b1;
    start_run(5'd1);
    c = 0;
    while (s_send !== 1'b1 && c < 10) begin @(negedge clk); c++; end
    tests++; if (c >= 10) begin failures++; $display("FAIL sent_tmo_issue: send_cmd=%b after %0d cycles, required 1", s_send, c); end
    repeat (20) @(negedge clk);
    tests++; if (s_err !== 1'b0) begin failures++; $display("FAIL sent_tmo_early: err=%b after 20 wait cycles, required 0", s_err); end
    @(negedge clk);
    tests++; if (s_err !== 1'b1) begin failures++; $display("FAIL sent_tmo_fire: err=%b after 21 wait cycles, required 1", s_err); end
    tests++; if (s_code !== 2'b01) begin failures++; $display("FAIL sent_tmo_code: got %b required 01", s_code); end
    wait_done(20, "sent_tmo");
    tests++; if (s_idx !== 4'd0) begin failures++; $display("FAIL sent_tmo_idx: got %0d required 0", s_idx); end
    tests++; if (s_pass !== 5'd0) begin failures++; $display("FAIL sent_tmo_pass_cnt: got %0d required 0", s_pass); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_same_cycle();
    cfg_default();
    same_cyc[0] = 1'b1;
    sent_dly = 5;
    resp_tmo = 24'd3;
    start_run(5'd1);
    wait_done(100, "same");
    tests++; if (s_err !== 1'b0) begin failures++; $display("FAIL same_err: got %b code %b required err 0", s_err, s_code); end
    tests++; if (s_pass !== 5'd1) begin failures++; $display("FAIL same_pass_cnt: got %0d required 1", s_pass); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_abort_and_empty();
    cfg_default();
    drop_resp[0] = 1'b1;
    start_run(5'd1);
    repeat (10) @(negedge clk);
    tests++; if (s_busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy: got %b required 1", s_busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++; if (s_busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b required 0", s_busy); end
    tests++; if (s_done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b required 0", s_done); end
    tests++; if (s_send !== 1'b0) begin failures++; $display("FAIL abort_send: got %b required 0", s_send); end
    repeat (5) @(negedge clk);
    tests++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin failures++; $display("FAIL abort_stays_idle: busy=%b done=%b required 0 0", s_busy, s_done); end
    start_run(5'd0);
    tests++; if (s_busy !== 1'b1) begin failures++; $display("FAIL empty_busy: got %b required 1", s_busy); end
    wait_done(10, "empty");
    tests++; if (s_pass !== 5'd0) begin failures++; $display("FAIL empty_pass_cnt: got %0d required 0", s_pass); end
    tests++; if (s_err !== 1'b0) begin failures++; $display("FAIL empty_err: got %b required 0", s_err); end
    repeat (3) @(negedge clk);
    tests++; if (npulse !== 0) begin failures++; $display("FAIL empty_pulses: got %0d required 0", npulse); end
  endtask

  task automatic test_async_reset();
    cfg_default();
    start_run(5'd4);
    repeat (15) @(negedge clk);
    tests++; if (s_busy !== 1'b1) begin failures++; $display("FAIL arst_pre_busy: got %b required 1", s_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (s_busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b required 0", s_busy); end
    tests++; if (s_done !== 1'b0) begin failures++; $display("FAIL arst_done: got %b required 0", s_done); end
    tests++; if (s_err !== 1'b0 || s_code !== 2'b00 || s_idx !== 4'd0) begin failures++; $display("FAIL arst_err: err=%b code=%b idx=%0d required 0 00 0", s_err, s_code, s_idx); end
    tests++; if (s_pass !== 5'd0) begin failures++; $display("FAIL arst_pass_cnt: got %0d required 0", s_pass); end
    tests++; if (s_send !== 1'b0 || s_cmd !== 16'h0000) begin failures++; $display("FAIL arst_bus: send=%b cmd=%h required 0 0000", s_send, s_cmd); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tests = 0; failures = 0; run_id = 0; use1 = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_cmd = '0; wr_exp = '0; wr_chk = 1'b0;
    num_cmds = '0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    cfg_default();
    test_reset();
    test_single();
    test_four_moves();
    test_stop_on_err();
    test_continue_on_err();
    test_sent_timeout();
    test_same_cycle();
    test_abort_and_empty();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
